// File: rtl/iter_div_64_32_if.sv
// Handshake and operand bundle for the iterative divider.
// The master side is the issuing pipeline stage; the slave side is the divider.
interface iter_div_64_32_if #(
  parameter int XLEN = `ifdef RV32GC_ISA 32 `else 64 `endif
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic            is_word;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output flush, in_valid, op, is_word, dividend, divisor, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  flush, in_valid, op, is_word, dividend, divisor, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/iter_div_64_32.sv
// Radix-2 non-restoring divider for DIV/DIVU/REM/REMU and the RV64 W variants.
// One subtract/add-back step per cycle on an XLEN+1-bit partial remainder.
//
// state | meaning
// IDLE  | ready for a new operation; special cases resolve straight to DONE
// PREP  | operand width/sign conditioning, absolute values, counter load
// CALC  | one quotient bit per cycle, N cycles
// FIX   | remainder correction, sign fix-up, quotient/remainder select
// DONE  | result presented until the consumer takes it
module iter_div_64_32 #(
  parameter int XLEN = `ifdef RV32GC_ISA 32 `else 64 `endif
) (
  input  logic             clk,
  input  logic             rst_n,
  iter_div_64_32_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] divr_q, divr_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = {XLEN{x[31]}};
    r[31:0] = x;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = x;
    return r;
  endfunction

  logic            accept;
  logic            word_in;
  logic            signed_in;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] dvd_w;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            sgn_op;
  logic            msb;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_n;
  logic [XLEN-1:0] rem_f;
  logic [XLEN-1:0] quo_s;
  logic [XLEN-1:0] rem_s;
  logic [XLEN-1:0] sel;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    word_d    = word_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divr_d    = divr_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    accept    = bus.in_valid && (state_q == S_IDLE) && !bus.flush;
    word_in   = (XLEN == 64) && bus.is_word;
    signed_in = ~bus.op[0];
    dvd_w     = word_in ? sext32(bus.dividend[31:0]) : bus.dividend;
    div_zero  = word_in ? (bus.divisor[31:0] == 32'h0) : (bus.divisor == '0);
    ovf       = signed_in &&
                (word_in ? ((bus.dividend[31:0] == 32'h8000_0000) &&
                            (bus.divisor[31:0] == 32'hFFFF_FFFF))
                         : ((bus.dividend == MIN_NEG) && (bus.divisor == '1)));

    sgn_op = ~op_q[0];
    if (word_q) begin
      a_ext = sgn_op ? sext32(a_q[31:0]) : zext32(a_q[31:0]);
      b_ext = sgn_op ? sext32(b_q[31:0]) : zext32(b_q[31:0]);
    end else begin
      a_ext = a_q;
      b_ext = b_q;
    end

    // W ops only iterate 32 times, so the bit fed into the remainder comes from bit 31
    msb    = word_q ? quo_q[31] : quo_q[XLEN-1];
    rem_sh = {rem_q[XLEN-1:0], msb};
    rem_n  = rem_q[XLEN] ? (rem_sh + {1'b0, divr_q}) : (rem_sh - {1'b0, divr_q});

    rem_f = rem_q[XLEN-1:0] + (rem_q[XLEN] ? divr_q : '0);
    quo_s = neg_quo_q ? (-quo_q) : quo_q;
    rem_s = neg_rem_q ? (-rem_f) : rem_f;
    sel   = op_q[1] ? rem_s : quo_s;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = bus.op;
          word_d = word_in;
          a_d    = bus.dividend;
          b_d    = bus.divisor;
          if (div_zero) begin
            result_d = bus.op[1] ? dvd_w : '1;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = bus.op[1] ? '0 : dvd_w;
            state_d  = S_DONE;
          end else begin
            state_d = S_PREP;
          end
        end
      end
      S_PREP: begin
        neg_quo_d = sgn_op && (a_ext[XLEN-1] ^ b_ext[XLEN-1]);
        neg_rem_d = sgn_op && a_ext[XLEN-1];
        quo_d     = (sgn_op && a_ext[XLEN-1]) ? (-a_ext) : a_ext;
        divr_d    = (sgn_op && b_ext[XLEN-1]) ? (-b_ext) : b_ext;
        rem_d     = '0;
        cnt_d     = word_q ? 7'd32 : 7'(XLEN);
        state_d   = S_CALC;
      end
      S_CALC: begin
        rem_d = rem_n;
        quo_d = {quo_q[XLEN-2:0], ~rem_n[XLEN]};
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = word_q ? sext32(sel[31:0]) : sel;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      word_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divr_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      word_q    <= word_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divr_q    <= divr_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_iter_div_64_32.sv
// Bench for iter_div_64_32 at XLEN=64: directed cases, a few random operations
// against a behavioural model, flush, output back-pressure and mid-operation reset.
module tb_iter_div_64_32;

  localparam int XLEN = 64;
  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  logic clk_sys;
  logic rst_n;

  iter_div_64_32_if #(.XLEN(XLEN)) bus ();

  iter_div_64_32 #(.XLEN(XLEN)) dut (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] q, r;
    logic [31:0] a32, b32, q32, r32;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) begin
        q32 = '1; r32 = a32;
      end else if (!op[0] && a32 == 32'h8000_0000 && b32 == '1) begin
        q32 = a32; r32 = '0;
      end else if (!op[0]) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      return sx32(op[1] ? r32 : q32);
    end
    if (b == 0) begin
      q = '1; r = a;
    end else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a; r = '0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    if (w && (b[31:0] == 0 || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == '1)))
      return 1;
    if (!w && (b == 0 || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1)))
      return 1;
    return w ? 35 : 67;
  endfunction

  // Drive one operation and wait for its accept edge; returns at accept edge + 1.
  task automatic accept_op(input logic [1:0] op, input logic w,
                           input logic [63:0] a, input logic [63:0] b);
    bus.op       = op;
    bus.is_word  = w;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    exp_t        e;
    int          lat;
    logic [63:0] held;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk_sys);
      #1;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_res"}, bus.result, e.res);
    chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
    if (hold > 0) begin
      held = bus.result;
      bus.in_valid = 1'b1;
      bus.dividend = 64'd99;
      bus.divisor  = 64'd3;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk_sys);
        #1;
        chk({tag, "_hold_res"}, bus.result, held);
        chk({tag, "_hold_ov"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_hold_ir"}, 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_drain"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat, input int hold);
    exp_t e;
    e.res = exp_res;
    e.lat = exp_lat;
    sb.push_back(e);
    accept_op(op, w, a, b);
    collect(tag, hold);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [1:0]  rop;
    logic        rw;
    logic        seen;

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.is_word   = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_state", {bus.result, bus.out_valid, bus.in_ready} == {64'd0, 1'b0, 1'b1}, 1);
    rst_n = 1'b1;
    @(posedge clk_sys);
    #1;

    run_op("div_m7_2",   OP_DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, 0);
    run_op("rem_m7_2",   OP_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67, 0);
    run_op("divu_z",     OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("remu_z",     OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("div_ovf",    OP_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ovf",    OP_REM,  1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    run_op("divw_ovf",   OP_DIV,  1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("divuw",      OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 35, 0);
    run_op("remw",       OP_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 35, 0);

    for (int i = 0; i < 10; i++) begin
      ra  = {$urandom, $urandom};
      rb  = (i < 5) ? {$urandom, $urandom} >> $urandom_range(60, 0) : 64'($urandom_range(1000, 0)) - 64'd500;
      rop = 2'($urandom_range(3, 0));
      rw  = (i % 3 == 2);
      run_op($sformatf("rnd%0d", i), rop, rw, ra, rb, model(rop, rw, ra, rb),
             model_lat(rop, rw, ra, rb), 0);
    end

    accept_op(OP_DIVU, 1'b0, 64'd123456789, 64'd11);
    repeat (10) @(posedge clk_sys);
    #1;
    bus.flush = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.flush = 1'b0;
    chk("flush_rdy", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk_sys);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush_no_out", 64'(seen), 64'd0);
    run_op("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 67, 0);

    run_op("hold", OP_DIV, 1'b0, 64'd1000, -64'sd33, model(OP_DIV, 1'b0, 64'd1000, -64'sd33), 67, 5);

    accept_op(OP_DIV, 1'b0, 64'd5000, 64'd7);
    repeat (20) @(posedge clk_sys);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {bus.result, bus.out_valid, bus.in_ready} == {64'd0, 1'b0, 1'b1}, 1);
    #1;
    rst_n = 1'b1;
    @(posedge clk_sys);
    #1;
    run_op("post_rst", OP_REMU, 1'b0, 64'd5000, 64'd7, 64'd2, 67, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
